// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program-memory fetch initiator (port A side).
// Issues word-aligned reads into a fixed-latency pipelined bus, tags each
// response with its address, buffers {pc, instr} in a prefetch FIFO and
// serves decode over a valid/ready handshake. A redirect clears the FIFO
// and discards responses still owed to the old stream.
// Optional feature macro: FETCH_PERF_COUNTERS_EN (accepted/dropped counters).
module instr_fetch_unit #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        fetch_en_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] mem_addr_out,
  output logic        mem_read_request_out,
  input  logic [31:0] mem_instr_in,
  input  logic        mem_data_valid_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] fetched_count_out,
  output logic [15:0] dropped_count_out
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q;
  logic [CW-1:0] drop_cnt_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   mem_addr_q;
  logic          mem_req_q;
  logic [31:0]   pc_pipe_q [MEM_LATENCY];
  entry_t        fifo_mem  [FIFO_DEPTH];
  entry_t        head;

  logic [CW:0]   occ_sum;
  logic          issue;
  logic          resp_ok;
  logic          push;
  logic          pop;

  // inflight already includes the request being driven this cycle, so
  // occupancy + inflight covers every FIFO slot a response may still need.
  assign occ_sum    = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue      = fetch_en_in && !redirect_in && (occ_sum < DEPTH_W);
  assign resp_ok    = mem_data_valid_in && (inflight_q != '0);
  assign push       = resp_ok && !redirect_in && (state_q == RUN);
  assign pop        = (count_q != '0) && instr_ready_in && !redirect_in;
  assign inflight_d = inflight_q + CW'(issue) - CW'(resp_ok);

  // Request side: registered bus outputs, fetch pc and outstanding count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (redirect_in) begin
        mem_req_q  <= 1'b0;
        fetch_pc_q <= redirect_pc_in & ~32'h3;
      end else if (issue) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end else begin
        mem_req_q  <= 1'b0;
      end
    end
  end

  // Flush FSM: counts responses still owed to the stream a redirect abandoned.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= RUN;
      drop_cnt_q <= '0;
    end else if (redirect_in) begin
      drop_cnt_q <= inflight_q - CW'(resp_ok);
      state_q    <= ((inflight_q - CW'(resp_ok)) != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN: ;
        FLUSH: begin
          if (resp_ok) begin
            drop_cnt_q <= drop_cnt_q - CW'(1);
            if (drop_cnt_q == CW'(1)) state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Address tag pipeline and FIFO storage: pure data, shifted/written blindly.
  // NOTE: these arrays carry no reset; validity comes from the FIFO count and
  // the fixed response timing, so resetting them would only add cost.
  always_ff @(posedge clk_in) begin
    pc_pipe_q[0] <= mem_addr_q;
    for (int i = 1; i < MEM_LATENCY; i++) pc_pipe_q[i] <= pc_pipe_q[i-1];
    if (push) fifo_mem[wr_ptr_q] <= '{pc: pc_pipe_q[MEM_LATENCY-1], instr: mem_instr_in};
  end

  // FIFO pointers and occupancy; a redirect empties the queue at the edge.
  always_ff @(posedge clk_in) begin
    if (rst_in || redirect_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head                 = fifo_mem[rd_ptr_q];
  assign instr_valid_out      = (count_q != '0);
  assign instr_out            = instr_valid_out ? head.instr : 32'h0;
  assign pc_out               = instr_valid_out ? head.pc    : 32'h0;
  assign mem_addr_out         = mem_addr_q;
  assign mem_read_request_out = mem_req_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetched_q;
  logic [15:0] dropped_q;
  logic        drop;

  assign drop = resp_ok && (redirect_in || (state_q == FLUSH));

  // Performance counters: accepted instructions wrap, drops saturate.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      if (pop) fetched_q <= fetched_q + 32'd1;
      if (drop && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign fetched_count_out = fetched_q;
  assign dropped_count_out = dropped_q;
`else
  assign fetched_count_out = 32'h0;
  assign dropped_count_out = 16'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a 2-cycle pipelined memory responder plus a
// transaction-level reference model (queues of outstanding reads and
// prefetched entries) checked every cycle, with directed scenarios followed
// by a randomized phase.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5A5A5;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        fetch_en_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] mem_addr_out;
  logic        mem_read_request_out;
  logic [31:0] mem_instr_in;
  logic        mem_data_valid_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] fetched_count_out;
  logic [15:0] dropped_count_out;

  always #5 clk_in = ~clk_in;

  instr_fetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RESET_PC),
    .MEM_LATENCY(2)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .fetch_en_in         (fetch_en_in),
    .redirect_in         (redirect_in),
    .redirect_pc_in      (redirect_pc_in),
    .mem_addr_out        (mem_addr_out),
    .mem_read_request_out(mem_read_request_out),
    .mem_instr_in        (mem_instr_in),
    .mem_data_valid_in   (mem_data_valid_in),
    .instr_out           (instr_out),
    .pc_out              (pc_out),
    .instr_valid_out     (instr_valid_out),
    .instr_ready_in      (instr_ready_in),
    .fetched_count_out   (fetched_count_out),
    .dropped_count_out   (dropped_count_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory responder: two-stage pipeline of sampled requests.
  logic        mv0, mv1;
  logic [31:0] ma0, ma1;

  // Reference model: reads not yet answered, and entries waiting for decode.
  typedef struct { logic [31:0] addr; bit stale; } os_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } pf_t;
  os_t         os_q[$];
  pf_t         pf_q[$];
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;
  logic [31:0] m_fetched;
  logic [15:0] m_dropped;

  logic [31:0] req_log[$];
  logic [31:0] acc_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    os_q.delete();
    pf_q.delete();
    m_req     = 1'b0;
    m_addr    = RESET_PC;
    m_fpc     = RESET_PC;
    m_fetched = '0;
    m_dropped = '0;
  endtask

  task automatic model_update();
    os_t e;
    int  occ, infl;
    bit  do_issue;
    if (rst_in) begin
      model_reset();
      return;
    end
    occ      = pf_q.size();
    infl     = os_q.size();
    do_issue = fetch_en_in && !redirect_in && (occ + infl < DEPTH);
    if (occ > 0 && instr_ready_in && !redirect_in) begin
      void'(pf_q.pop_front());
      m_fetched++;
    end
    if (mem_data_valid_in && infl > 0) begin
      e = os_q.pop_front();
      if (e.stale || redirect_in) begin
        if (m_dropped != 16'hFFFF) m_dropped++;
      end else begin
        pf_q.push_back('{pc: e.addr, instr: e.addr ^ KEY});
      end
    end
    if (redirect_in) begin
      pf_q.delete();
      foreach (os_q[i]) os_q[i].stale = 1'b1;
      m_fpc = redirect_pc_in & ~32'h3;
      m_req = 1'b0;
    end else if (do_issue) begin
      m_req  = 1'b1;
      m_addr = m_fpc;
      os_q.push_back('{addr: m_fpc, stale: 1'b0});
      m_fpc  = m_fpc + 32'd4;
    end else begin
      m_req = 1'b0;
    end
  endtask

  // One clock cycle: present memory response, compare all outputs against
  // the model, advance the model, then cross the rising edge.
  task automatic step();
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] exp_f, exp_d;
    mem_data_valid_in = mv1;
    mem_instr_in      = mv1 ? (ma1 ^ KEY) : $urandom;
`ifdef FETCH_PERF_COUNTERS_EN
    exp_f = m_fetched;
    exp_d = {16'h0, m_dropped};
`else
    exp_f = 32'h0;
    exp_d = 32'h0;
`endif
    check("req",   {31'h0, mem_read_request_out}, {31'h0, m_req});
    check("addr",  mem_addr_out, m_addr);
    check("valid", {31'h0, instr_valid_out}, {31'h0, pf_q.size() != 0});
    if (pf_q.size() != 0) begin
      check("pc",    pc_out,    pf_q[0].pc);
      check("instr", instr_out, pf_q[0].instr);
    end
    check("fetched", fetched_count_out, exp_f);
    check("dropped", {16'h0, dropped_count_out}, exp_d);
    if (mem_read_request_out === 1'b1) req_log.push_back(mem_addr_out);
    if (instr_valid_out === 1'b1 && instr_ready_in && !redirect_in && !rst_in)
      acc_log.push_back(pc_out);
    req_s  = mem_read_request_out;
    addr_s = mem_addr_out;
    model_update();
    @(posedge clk_in);
    @(negedge clk_in);
    if (rst_in) begin
      mv0 = 1'b0;
      mv1 = 1'b0;
    end else begin
      mv1 = mv0;
      ma1 = ma0;
      mv0 = req_s;
      ma0 = addr_s;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},    mem_addr_out, RESET_PC);
    check({tag, "_req"},     {31'h0, mem_read_request_out}, 32'h0);
    check({tag, "_valid"},   {31'h0, instr_valid_out}, 32'h0);
    check({tag, "_pc"},      pc_out, 32'h0);
    check({tag, "_instr"},   instr_out, 32'h0);
    check({tag, "_fetched"}, fetched_count_out, 32'h0);
    check({tag, "_dropped"}, {16'h0, dropped_count_out}, 32'h0);
  endtask

  initial begin
    logic [15:0] d_base;
    rst_in = 1'b1; fetch_en_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
    instr_ready_in = 1'b0; mem_data_valid_in = 1'b0; mem_instr_in = '0;
    mv0 = 1'b0; mv1 = 1'b0; ma0 = '0; ma1 = '0;
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("rst0");
    step();

    // Streaming from reset: first request in cycle 1, contiguous pcs.
    rst_in = 1'b0; fetch_en_in = 1'b1; instr_ready_in = 1'b1;
    req_log.delete(); acc_log.delete();
    step();
    check("s1_first_req",  {31'h0, mem_read_request_out}, 32'h1);
    check("s1_first_addr", mem_addr_out, RESET_PC);
    repeat (100) step();
    check("s1_acc_count_ge64", {31'h0, acc_log.size() >= 64}, 32'h1);
    for (int i = 0; i < 64; i++) check("s1_seq", at(acc_log, i), RESET_PC + 32'(4 * i));

    // Decode stalled: requests stop once the FIFO can be filled.
    rst_in = 1'b1; fetch_en_in = 1'b0; instr_ready_in = 1'b0;
    step();
    rst_in = 1'b0; fetch_en_in = 1'b1;
    req_log.delete(); acc_log.delete();
    repeat (12) step();
    check("s2_req_count", req_log.size(), 32'd4);
    check("s2_last_addr", at(req_log, 3), 32'hC);
    instr_ready_in = 1'b1;
    req_log.delete();
    repeat (10) step();
    check("s2_resume_addr", at(req_log, 0), 32'h10);
    for (int i = 0; i < 4; i++) check("s2_acc", at(acc_log, i), 32'(4 * i));

    // Redirect with exactly two reads outstanding.
    fetch_en_in = 1'b0;
    repeat (8) step();
    fetch_en_in = 1'b1;
    repeat (2) step();
    d_base = m_dropped;
    fetch_en_in = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h1003;
    step();
    redirect_in = 1'b0;
    check("s3_valid_low", {31'h0, instr_valid_out}, 32'h0);
    fetch_en_in = 1'b1;
    req_log.delete(); acc_log.delete();
    repeat (10) step();
    check("s3_new_addr", at(req_log, 0), 32'h1000);
    check("s3_first_pc", at(acc_log, 0), 32'h1000);
`ifdef FETCH_PERF_COUNTERS_EN
    check("s3_dropped", {16'h0, dropped_count_out}, {16'h0, d_base + 16'd2});
`else
    check("s3_dropped", {16'h0, dropped_count_out}, 32'h0);
`endif

    // Redirect coincident with a response and a pop, then a second redirect.
    for (int i = 0; i < 20 && !(mv0 && instr_valid_out === 1'b1); i++) step();
    check("s4_coincident", {31'h0, mv0 && instr_valid_out === 1'b1}, 32'h1);
    redirect_in = 1'b1; redirect_pc_in = 32'h200;
    step();
    acc_log.delete();
    redirect_pc_in = 32'h300;
    step();
    redirect_in = 1'b0;
    repeat (10) step();
    check("s4_first_pc", at(acc_log, 0), 32'h300);

    // Address wrap at the top of the 32-bit space.
    redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFF8;
    step();
    redirect_in = 1'b0;
    req_log.delete();
    repeat (8) step();
    check("s5_wrap0", at(req_log, 0), 32'hFFFF_FFF8);
    check("s5_wrap1", at(req_log, 1), 32'hFFFF_FFFC);
    check("s5_wrap2", at(req_log, 2), 32'h0000_0000);
    check("s5_wrap3", at(req_log, 3), 32'h0000_0004);

    // Fetch disabled with reads outstanding, data retained, then reset.
    instr_ready_in = 1'b0;
    step();
    fetch_en_in = 1'b0;
    repeat (4) step();
    check("s6_retained", {31'h0, instr_valid_out}, 32'h1);
    rst_in = 1'b1;
    step();
    check_reset_outputs("s6_rst");
    rst_in = 1'b0; fetch_en_in = 1'b1; instr_ready_in = 1'b1;
    req_log.delete();
    repeat (4) step();
    check("s6_first_addr", at(req_log, 0), RESET_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      fetch_en_in    = ($urandom_range(0, 9) != 0);
      instr_ready_in = ($urandom_range(0, 3) != 0);
      redirect_in    = ($urandom_range(0, 19) == 0);
      redirect_pc_in = $urandom;
      rst_in         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_in = 1'b0; redirect_in = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
